// File: rtl/mem_io_subsystem_if.sv
// mem_io_subsystem_if: processor external bus (address, write data, write strobe, read data)
interface mem_io_subsystem_if;
  logic [15:0] ADDR;
  logic [15:0] DOUT;
  logic        W;
  logic [15:0] DIN;
  modport master (output ADDR, DOUT, W, input DIN);
  modport slave (input ADDR, DOUT, W, output DIN);
endinterface

// File: rtl/mem_io_subsystem.sv
// mem_io_subsystem: word RAM, LED register, synchronized switches and interval timer on the processor bus
module mem_io_subsystem #(
  parameter int RAM_AW = 12,
  parameter int NLED = 10
) (
  input  logic              Clock,
  input  logic              Resetn,
  mem_io_subsystem_if.slave bus,
  input  logic [NLED-1:0]   SW,
  output logic [NLED-1:0]   LEDR,
  output logic              IRQ
);
  typedef enum logic {IDLE, RUN} state_t;
  state_t r_state, w_state_n;
  logic [15:0] r_ram [2**RAM_AW];
  logic [15:0] r_ram_q, r_prd, r_period, r_count, w_count_n, w_rd;
  logic [NLED-1:0] r_led, r_sw1, r_sw2;
  logic r_sel_ram, r_cont, r_irqen, r_to, r_irq, w_to_set;
  logic [3:0] w_region;
  logic w_tmr, w_ctrl_wr, w_per_wr, w_stat_wr, w_start, w_stop;
  assign w_region = bus.ADDR[15:12];
  assign w_tmr = w_region == 4'h4;
  assign w_ctrl_wr = bus.W && w_tmr && bus.ADDR[1:0] == 2'd0;
  assign w_per_wr = bus.W && w_tmr && bus.ADDR[1:0] == 2'd1;
  assign w_stat_wr = bus.W && w_tmr && bus.ADDR[1:0] == 2'd3;
  assign w_start = w_ctrl_wr && bus.DOUT[0];
  assign w_stop = w_ctrl_wr && bus.DOUT[1];
  // Peripheral read data is taken from pre-edge state and registered alongside the RAM output
  assign w_rd = w_region == 4'h1 ? 16'(r_led) :
                w_region == 4'h3 ? 16'(r_sw2) :
                !w_tmr ? 16'h0000 :
                bus.ADDR[1:0] == 2'd0 ? {12'b0, r_irqen, r_cont, 1'b0, r_state == RUN} :
                bus.ADDR[1:0] == 2'd1 ? r_period :
                bus.ADDR[1:0] == 2'd2 ? r_count : {15'b0, r_to};
  always_comb begin
    w_state_n = r_state;
    w_count_n = r_count;
    w_to_set = 1'b0;
    if (r_state == IDLE) begin
      w_state_n = w_start && !w_stop ? RUN : IDLE;
      w_count_n = w_start && !w_stop ? r_period : r_count;
    end else if (w_stop) begin
      w_state_n = IDLE;
    end else if (w_start) begin
      w_count_n = r_period;
    end else if (r_count == 16'd0) begin
      w_to_set = 1'b1;
      w_count_n = r_cont ? r_period : r_count;
      w_state_n = r_cont ? RUN : IDLE;
    end else begin
      w_count_n = r_count - 16'd1;
    end
  end
  always_ff @(posedge Clock) begin
    if (!Resetn) r_state <= IDLE;
    else r_state <= w_state_n;
  end
  always_ff @(posedge Clock) begin
    if (!Resetn) begin
      r_count <= '0;
      r_period <= '0;
      r_cont <= 1'b0;
      r_irqen <= 1'b0;
      r_to <= 1'b0;
      r_irq <= 1'b0;
      r_led <= '0;
      r_sw1 <= '0;
      r_sw2 <= '0;
      r_sel_ram <= 1'b0;
      r_prd <= '0;
    end else begin
      r_count <= w_count_n;
      r_to <= w_to_set | (r_to & ~w_stat_wr);
      r_irq <= r_to & r_irqen;
      r_sw1 <= SW;
      r_sw2 <= r_sw1;
      r_sel_ram <= w_region == 4'h0;
      r_prd <= w_rd;
      if (bus.W && w_region == 4'h1) r_led <= bus.DOUT[NLED-1:0];
      if (w_per_wr) r_period <= bus.DOUT;
      if (w_ctrl_wr) begin
        r_cont <= bus.DOUT[2];
        r_irqen <= bus.DOUT[3];
      end
    end
  end
  always_ff @(posedge Clock) begin
    if (Resetn && bus.W && w_region == 4'h0) r_ram[bus.ADDR[RAM_AW-1:0]] <= bus.DOUT;
    r_ram_q <= r_ram[bus.ADDR[RAM_AW-1:0]];
  end
  assign bus.DIN = r_sel_ram ? r_ram_q : r_prd;
  assign LEDR = r_led;
  assign IRQ = r_irq;
endmodule

// File: tb/tb_mem_io_subsystem.sv
// tb_mem_io_subsystem: table, directed and random checks against a cycle-level reference model
module tb_mem_io_subsystem;
  logic Clock = 1'b0;
  logic Resetn = 1'b0;
  logic [9:0] SW = '0;
  logic [9:0] LEDR;
  logic IRQ;
  mem_io_subsystem_if bus();
  mem_io_subsystem #(.RAM_AW(12), .NLED(10)) dut (
    .Clock(Clock), .Resetn(Resetn), .bus(bus), .SW(SW), .LEDR(LEDR), .IRQ(IRQ)
  );
  always #5 Clock = ~Clock;
  int n_pass = 0, n_total = 0;
  logic [15:0] m_ram [4096];
  bit m_known [4096];
  logic [9:0] m_led = '0, m_sw1 = '0, m_sw2 = '0;
  logic [15:0] m_period = '0, m_frozen = '0, m_din = '0;
  bit m_run, m_cont, m_irqen, m_to, m_irq, m_din_ok;
  int m_edge = 0, m_fire = 0;
  typedef struct {
    logic [15:0] a;
    logic [15:0] d;
    bit w;
    bit chk;
    logic [15:0] din;
    logic [9:0] led;
  } vec_t;
  vec_t tv[12];
  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask
  // Timer kept as an absolute deadline edge; COUNT is derived from the distance to it
  task automatic model(input logic [15:0] a, input logic [15:0] d, input bit w, input bit rn);
    logic [3:0] rg;
    logic [15:0] cnt, rd;
    bit tmo, cw;
    m_edge++;
    if (!rn) begin
      m_led = '0; m_sw1 = '0; m_sw2 = '0; m_period = '0; m_frozen = '0;
      m_run = 0; m_cont = 0; m_irqen = 0; m_to = 0; m_irq = 0;
      m_din = '0; m_din_ok = 1;
      return;
    end
    rg = a[15:12];
    tmo = 0;
    cnt = m_run ? 16'(m_fire - m_edge) : m_frozen;
    m_din_ok = 1;
    rd = '0;
    if (rg == 4'h0) begin
      rd = m_ram[a[11:0]];
      m_din_ok = m_known[a[11:0]];
    end else if (rg == 4'h1) rd = {6'b0, m_led};
    else if (rg == 4'h3) rd = {6'b0, m_sw2};
    else if (rg == 4'h4) begin
      case (a[1:0])
        2'd0: rd = {12'b0, m_irqen, m_cont, 1'b0, m_run};
        2'd1: rd = m_period;
        2'd2: rd = cnt;
        default: rd = {15'b0, m_to};
      endcase
    end
    m_din = rd;
    m_irq = m_to & m_irqen;
    m_sw2 = m_sw1;
    m_sw1 = SW;
    cw = w && rg == 4'h4 && a[1:0] == 2'd0;
    if (m_run) begin
      if (cw && d[1]) begin
        m_run = 0;
        m_frozen = cnt;
      end else if (cw && d[0]) m_fire = m_edge + int'(m_period) + 1;
      else if (m_edge == m_fire) begin
        tmo = 1;
        if (m_cont) m_fire = m_edge + int'(m_period) + 1;
        else begin
          m_run = 0;
          m_frozen = '0;
        end
      end
    end else if (cw && d[0] && !d[1]) begin
      m_run = 1;
      m_fire = m_edge + int'(m_period) + 1;
    end
    m_to = tmo || (m_to && !(w && rg == 4'h4 && a[1:0] == 2'd3));
    if (cw) begin
      m_cont = d[2];
      m_irqen = d[3];
    end
    if (w && rg == 4'h4 && a[1:0] == 2'd1) m_period = d;
    if (w && rg == 4'h1) m_led = d[9:0];
    if (w && rg == 4'h0) begin
      m_ram[a[11:0]] = d;
      m_known[a[11:0]] = 1;
    end
  endtask
  task automatic step(input logic [15:0] a, input logic [15:0] d, input bit w, input bit rn);
    bus.ADDR = a;
    bus.DOUT = d;
    bus.W = w;
    Resetn = rn;
    @(posedge Clock);
    model(a, d, w, rn);
    #1;
    if (m_din_ok) chk("model_din", bus.DIN, m_din);
    chk("model_ledr", 16'(LEDR), 16'(m_led));
    chk("model_irq", 16'(IRQ), 16'(m_irq));
  endtask
  initial begin
    logic [15:0] a, d;
    bit w, rn;
    int sel;
    tv[0]  = '{16'h0005, 16'hBEEF, 1, 0, 16'h0000, 10'h000};
    tv[1]  = '{16'h0005, 16'h0000, 0, 1, 16'hBEEF, 10'h000};
    tv[2]  = '{16'h0005, 16'h1234, 1, 1, 16'hBEEF, 10'h000};
    tv[3]  = '{16'h0005, 16'h0000, 0, 1, 16'h1234, 10'h000};
    tv[4]  = '{16'h1000, 16'h03FF, 1, 1, 16'h0000, 10'h3FF};
    tv[5]  = '{16'h1000, 16'h0000, 0, 1, 16'h03FF, 10'h3FF};
    tv[6]  = '{16'h3000, 16'hFFFF, 1, 1, 16'h0000, 10'h3FF};
    tv[7]  = '{16'h7000, 16'h0000, 0, 1, 16'h0000, 10'h3FF};
    tv[8]  = '{16'h0000, 16'h5A5A, 1, 0, 16'h0000, 10'h3FF};
    tv[9]  = '{16'h2000, 16'hAAAA, 1, 1, 16'h0000, 10'h3FF};
    tv[10] = '{16'h0000, 16'h0000, 0, 1, 16'h5A5A, 10'h3FF};
    tv[11] = '{16'h1000, 16'h0000, 0, 1, 16'h03FF, 10'h3FF};
    step(16'h0, 16'h0, 0, 0);
    step(16'h0, 16'h0, 0, 0);
    chk("reset_din", bus.DIN, 16'h0000);
    chk("reset_ledr", 16'(LEDR), 16'h0000);
    chk("reset_irq", 16'(IRQ), 16'h0000);
    step(16'h0, 16'h0, 0, 1);
    for (int i = 0; i < 12; i++) begin
      step(tv[i].a, tv[i].d, tv[i].w, 1);
      if (tv[i].chk) chk($sformatf("vec%0d_din", i), bus.DIN, tv[i].din);
      chk($sformatf("vec%0d_ledr", i), 16'(LEDR), 16'(tv[i].led));
    end
    SW = 10'h155;
    for (int i = 1; i <= 5; i++) begin
      step(16'h3000, 16'h0, 0, 1);
      if (i >= 3) chk("sw_sync", bus.DIN, 16'h0155);
      else chk("sw_no_partial", 16'(bus.DIN == 16'h0000 || bus.DIN == 16'h0155), 16'h0001);
    end
    step(16'h4001, 16'h0004, 1, 1);
    step(16'h4000, 16'h0009, 1, 1);
    for (int i = 1; i <= 6; i++) begin
      step(16'h4003, 16'h0, 0, 1);
      chk($sformatf("oneshot_to_%0d", i), bus.DIN, 16'(i >= 6));
      chk($sformatf("oneshot_irq_%0d", i), 16'(IRQ), 16'(i >= 6));
    end
    step(16'h4002, 16'h0, 0, 1);
    chk("oneshot_count", bus.DIN, 16'h0000);
    step(16'h4000, 16'h0, 0, 1);
    chk("oneshot_ctrl", bus.DIN, 16'h0008);
    step(16'h4003, 16'h0, 1, 1);
    step(16'h4003, 16'h0, 0, 1);
    chk("clear_to", bus.DIN, 16'h0000);
    chk("clear_irq", 16'(IRQ), 16'h0000);
    step(16'h4001, 16'h0002, 1, 1);
    step(16'h4000, 16'h0005, 1, 1);
    for (int i = 1; i <= 9; i++) begin
      step(16'h4002, 16'h0, 0, 1);
      chk($sformatf("cont_count_%0d", i), bus.DIN, 16'(2 - ((i - 1) % 3)));
    end
    step(16'h4003, 16'h0, 1, 1);
    step(16'h4003, 16'h0, 0, 1);
    chk("cont_clear", bus.DIN, 16'h0000);
    step(16'h4003, 16'h0, 1, 1);
    step(16'h4003, 16'h0, 0, 1);
    chk("set_beats_clear", bus.DIN, 16'h0001);
    step(16'h4000, 16'h0002, 1, 1);
    step(16'h4002, 16'h0, 0, 1);
    chk("stop_count_a", bus.DIN, 16'h0001);
    step(16'h4002, 16'h0, 0, 1);
    chk("stop_count_b", bus.DIN, 16'h0001);
    step(16'h4000, 16'h0003, 1, 1);
    step(16'h4000, 16'h0, 0, 1);
    chk("start_stop_idle", bus.DIN, 16'h0000);
    step(16'h4002, 16'h0, 0, 1);
    chk("start_stop_count", bus.DIN, 16'h0001);
    step(16'h4001, 16'h0100, 1, 1);
    step(16'h4000, 16'h0009, 1, 1);
    step(16'h4002, 16'h0, 0, 1);
    chk("run_count", bus.DIN, 16'h0100);
    step(16'h1000, 16'h00F0, 1, 1);
    step(16'h0005, 16'hDEAD, 1, 0);
    chk("midrst_din", bus.DIN, 16'h0000);
    chk("midrst_ledr", 16'(LEDR), 16'h0000);
    chk("midrst_irq", 16'(IRQ), 16'h0000);
    step(16'h4002, 16'h0, 0, 1);
    chk("midrst_count", bus.DIN, 16'h0000);
    step(16'h4000, 16'h0, 0, 1);
    chk("midrst_ctrl", bus.DIN, 16'h0000);
    step(16'h0005, 16'h0, 0, 1);
    chk("midrst_ram5", bus.DIN, 16'h1234);
    step(16'h0000, 16'h0, 0, 1);
    chk("midrst_ram0", bus.DIN, 16'h5A5A);
    for (int k = 0; k < 500; k++) begin
      sel = $urandom_range(0, 9);
      if (sel < 2) a = 16'($urandom_range(0, 7));
      else if (sel == 2) a = 16'h1000;
      else if (sel == 3) a = 16'h3000;
      else if (sel == 4) a = {4'($urandom_range(5, 15)), 12'($urandom)};
      else a = 16'h4000 | 16'($urandom_range(0, 3));
      d = 16'($urandom);
      if (a[15:12] == 4'h4 && a[1:0] == 2'd1) d = d & 16'h0007;
      w = $urandom_range(0, 2) == 0;
      rn = $urandom_range(0, 79) != 0;
      if ($urandom_range(0, 15) == 0) SW = 10'($urandom);
      step(a, d, w, rn);
    end
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/mem_io_subsystem.md
Name: mem_io_subsystem

Overview:
- Memory and I/O slave on the processor's external bus. Consumes the processor's registered ADDR, DOUT and W, and returns read data on DIN with the single-cycle synchronous latency the processor's fetch and load timing expects.
- Contains an on-chip word RAM, a LED output register, a synchronized switch input port and a 16-bit interval timer with interrupt.
- Address decoding uses ADDR[15:12].

Parameters:
- RAM_AW, 12, RAM address width; RAM holds 2^RAM_AW 16-bit words. Only ADDR[RAM_AW-1:0] is used inside the RAM region.
- NLED, 10, LED register and switch port width (NLED ≤ 16).

Ports:
- Clock  in  1  system clock; all state updates on the posedge.
- Resetn  in  1  reset, synchronous, active-low.
- ADDR  in  16  word address from the processor.
- DOUT  in  16  write data from the processor.
- W  in  1  write strobe; a write is performed at any posedge where W=1.
- DIN  out  16  read data to the processor.
- SW  in  NLED  asynchronous slide-switch inputs.
- LEDR  out  NLED  LED register contents.
- IRQ  out  1  timer interrupt, level.

Behaviour:
- Address map (region = ADDR[15:12]):
  - 0x0 RAM, read/write.
  - 0x1 LEDR, read/write.
  - 0x3 SW, read-only; writes are ignored.
  - 0x4 timer; ADDR[1:0] selects 0 CTRL, 1 PERIOD, 2 COUNT, 3 STATUS.
  - Any other region: reads return 0x0000, writes are ignored.
- Read latency is exactly 1 cycle:
  - DIN in cycle n+1 is the data at the ADDR presented in cycle n, as sampled at the posedge ending cycle n.
  - DIN holds that value until the next posedge.
  - There is no handshake and no wait state.
- RAM read-during-write to the same address returns the old data (read-first).
- Peripheral reads return register state before that edge's update.
- RAM contents are not cleared by reset.
- Reset values: DIN=0, LEDR=0, IRQ=0, PERIOD=0, COUNT=0, STATUS=0, CTRL fields=0, timer state=IDLE, switch synchronizer=0.
- LEDR:
  - A write loads DOUT[NLED-1:0].
  - A read returns the register zero-extended to 16 bits.
- SW:
  - Two-flop synchronizer; a read returns the second stage, zero-extended.
  - A switch change is visible on DIN no earlier than 3 cycles after it occurs.
- Timer CTRL write fields:
  - bit0 START (pulse).
  - bit1 STOP (pulse).
  - bit2 CONT (stored).
  - bit3 IRQEN (stored).
- CTRL read returns {12'b0, IRQEN, CONT, 1'b0, running}.
- PERIOD is read/write and 16 bits.
- COUNT is read-only.
- STATUS:
  - bit0 TO (sticky) is the only defined bit.
  - Any write to STATUS clears TO.
  - Reads return {15'b0, TO}.
- Timer FSM, IDLE:
  - A write to CTRL with START=1 and STOP=0 loads COUNT<=PERIOD and moves to RUN.
  - If START and STOP are both set in the same write, STOP wins and the timer stays in IDLE.
- Timer FSM, RUN (each cycle):
  - If a CTRL write with STOP=1 occurs, go to IDLE; COUNT holds its value.
  - Else if a CTRL write with START=1 occurs, restart with COUNT<=PERIOD.
  - Else if COUNT==0, set TO. With CONT=1, COUNT<=PERIOD and stay in RUN; otherwise go to IDLE.
  - Else COUNT<=COUNT-1.
- The timeout period is PERIOD+1 cycles. PERIOD=0 with CONT=1 sets TO every cycle.
- If TO is set and a STATUS write occurs at the same edge, the set wins and TO=1.
- A PERIOD write while in RUN does not affect COUNT until the next reload.
- IRQ = TO & IRQEN, registered; it follows the internal values with 1-cycle delay.
- Resetn=0 at any edge, including mid-count or on a write edge, forces all reset values and suppresses that edge's write.

Test Plan:
- RAM write/read: W=1, ADDR=0x0005, DOUT=0xBEEF; then ADDR=0x0005 with W=0 -> DIN=0xBEEF in the following cycle. Read-during-write at 0x0005 with DOUT=0x1234 -> DIN=0xBEEF, then a re-read gives 0x1234.
- Map and decode: write 0x03FF to 0x1000 -> LEDR=0x3FF, read 0x1000 gives 0x03FF. Write to 0x3000 -> no effect. Read 0x7000 -> DIN=0x0000. Write 0xAAAA to 0x2000 -> RAM[0] unchanged.
- Switch sync: SW=0x155 applied -> reading 0x3000 returns 0x0155 within 3 cycles and never a partial value afterwards.
- Timer one-shot: PERIOD=4, CTRL=0x9 (START, IRQEN) -> TO=1 exactly 5 cycles after the START edge, IRQ one cycle later, timer then IDLE with COUNT=0. Write STATUS -> TO=0 and IRQ=0 next cycle.
- Timer continuous: PERIOD=2, CTRL=0x5 -> TO events every 3 cycles. STATUS write coinciding with a timeout edge -> TO stays 1. CTRL=0x3 -> remains IDLE. CTRL=0x2 -> COUNT frozen.
- Reset mid-operation: timer in RUN with COUNT=0x0100 and LEDR=0x0F0; Resetn=0 for one edge -> COUNT=0, IDLE, LEDR=0, DIN=0, IRQ=0, and RAM contents retained.
